regfile_dump_reader: RTL and testbench

Debug read-out engine for the 32-entry register file. On a start request it walks a programmable address range on one register-file read port and streams each register value, tagged with its index, over a valid/ready interface to a debug/trace consumer. It is the reader counterpart to the core's writeback path. It sits beside the register file and owns one read-address input while the core is halted or idle.

---
 rtl/regfile_dump_reader.sv | 144 ++++++++++++++
 tb/tb_regfile_dump_reader.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump_reader.sv
// -----------------------------------------------------------------------------
// regfile_dump_reader
//
// Debug read-out engine for the 32-entry register file. A start request walks
// the inclusive index range [first_addr, last_addr] on one register-file read
// port. Each register value is captured and streamed to a debug/trace consumer
// over a valid/ready interface, tagged with its index.
//
// Ports
//   clk        : system clock, rising edge
//   rst        : asynchronous, active-low reset
//   start      : dump request, only looked at while idle
//   first_addr : first register index of the range
//   last_addr  : last register index of the range (inclusive)
//   abort      : cancel an in-progress dump
//   RReg       : read address to the register-file read port
//   RD         : read data from the register file (combinational on RReg)
//   out_valid  : stream word valid
//   out_ready  : consumer ready
//   out_data   : captured register value
//   out_idx    : register index of out_data
//   out_last   : out_data is the final word of the range
//   busy       : dump in progress
//   done       : one-cycle pulse on normal completion
//   err        : one-cycle pulse when a start is rejected (first > last)
// -----------------------------------------------------------------------------
module regfile_dump_reader #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [4:0]   first_addr,
    input  logic [4:0]   last_addr,
    input  logic         abort,
    output logic [4:0]   RReg,
    input  logic [N-1:0] RD,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic [4:0]   out_idx,
    output logic         out_last,
    output logic         busy,
    output logic         done,
    output logic         err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t     state_r;
    logic [4:0] addr_r;
    logic [4:0] last_r;

    // The read port always follows the walking address, even while idle.
    assign RReg = addr_r;

    // Dump sequencer: state, address walk and all registered stream outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            addr_r    <= 5'd0;
            last_r    <= 5'd0;
            out_valid <= 1'b0;
            out_data  <= {N{1'b0}};
            out_idx   <= 5'd0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            // done and err are single-cycle pulses unless re-armed below.
            done <= 1'b0;
            err  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    // abort outranks start; a reversed range is refused.
                    if (start && !abort) begin
                        if (first_addr > last_addr) begin
                            err <= 1'b1;
                        end else begin
                            addr_r  <= first_addr;
                            last_r  <= last_addr;
                            busy    <= 1'b1;
                            state_r <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (abort) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        busy      <= 1'b0;
                        state_r   <= ST_IDLE;
                    end else begin
                        // Snapshot: later register-file writes cannot disturb it.
                        out_data  <= RD;
                        out_idx   <= addr_r;
                        out_last  <= (addr_r == last_r);
                        out_valid <= 1'b1;
                        state_r   <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (abort) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        busy      <= 1'b0;
                        state_r   <= ST_IDLE;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        if (out_last) begin
                            done    <= 1'b1;
                            state_r <= ST_DONE;
                        end else begin
                            // Last-word check precedes the increment, so no wrap.
                            addr_r  <= addr_r + 5'd1;
                            state_r <= ST_READ;
                        end
                    end
                end
                ST_DONE: begin
                    if (abort) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                    end
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    busy      <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
module tb_regfile_dump_reader;
    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic         out_ready = 1'b0;
    logic [4:0]   first_addr = 5'd0;
    logic [4:0]   last_addr = 5'd0;
    logic [4:0]   RReg;
    logic [N-1:0] RD;
    logic         out_valid;
    logic [N-1:0] out_data;
    logic [4:0]   out_idx;
    logic         out_last;
    logic         busy;
    logic         done;
    logic         err;

    logic [N-1:0] regs [32];

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic [4:0]   idx;
        logic [N-1:0] data;
        logic         last;
    } word_t;

    regfile_dump_reader #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .first_addr (first_addr),
        .last_addr  (last_addr),
        .abort      (abort),
        .RReg       (RReg),
        .RD         (RD),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_idx    (out_idx),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Register-file model: x0 is hard-wired to zero.
    always_comb RD = (RReg == 5'd0) ? {N{1'b0}} : regs[RReg];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one dump starting at the current negedge and checks every word.
    // rnd: random backpressure; hold: cycles of out_ready=0 on first word;
    // abort_at: word number during whose HOLD abort is raised (-1 = never).
    task automatic do_dump(input int f, input int l, input int rnd, input int hold, input int abort_at);
        word_t q[$];
        word_t w;
        int    cyc;
        int    words;
        int    hold_left;
        bit    pend_done;
        bit    fin;
        bit    prev_stall;
        for (int i = f; i <= l; i++) begin
            w.idx  = i[4:0];
            w.data = (i == 0) ? {N{1'b0}} : regs[i[4:0]];
            w.last = (i == l);
            q.push_back(w);
        end
        first_addr = f[4:0];
        last_addr  = l[4:0];
        start      = 1'b1;
        out_ready  = 1'b0;
        @(negedge clk);
        start      = 1'b0;
        first_addr = 5'($urandom);
        last_addr  = 5'($urandom);
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("valid_after_start", 32'(out_valid), 32'd0);
        cyc = 0; words = 0; hold_left = hold;
        pend_done = 1'b0; fin = 1'b0; prev_stall = 1'b0;
        while (!fin && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (abort) begin
                abort = 1'b0;
                chk("abort_valid", 32'(out_valid), 32'd0);
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_done", 32'(done), 32'd0);
                fin = 1'b1;
            end else if (pend_done) begin
                chk("done_pulse", 32'(done), 32'd1);
                chk("done_busy", 32'(busy), 32'd1);
                chk("done_valid", 32'(out_valid), 32'd0);
                if (rnd == 0 && hold == 0)
                    chk("dump_cycles", cyc, 2 * (l - f + 1));
                fin = 1'b1;
            end else begin
                chk("done_early", 32'(done), 32'd0);
                if (prev_stall)
                    chk("valid_held", 32'(out_valid), 32'd1);
                if (out_valid) begin
                    if (q.size() == 0) begin
                        chk("extra_word", 32'(out_valid), 32'd0);
                        fin = 1'b1;
                    end else begin
                        chk("idx", 32'(out_idx), 32'(q[0].idx));
                        chk("data", out_data, q[0].data);
                        chk("last", 32'(out_last), 32'(q[0].last));
                        if (words == abort_at) begin
                            abort     = 1'b1;
                            out_ready = 1'($urandom_range(1, 0));
                        end else if (words == 0 && hold_left > 0) begin
                            // Overwrite the already-captured register mid-hold.
                            if (hold_left == hold)
                                regs[q[0].idx] = ~regs[q[0].idx];
                            hold_left--;
                            out_ready = 1'b0;
                        end else begin
                            out_ready = (rnd != 0) ? 1'($urandom_range(1, 0)) : 1'b1;
                        end
                        if (out_ready && !abort) begin
                            void'(q.pop_front());
                            words++;
                            if (q.size() == 0) pend_done = 1'b1;
                        end
                        prev_stall = !out_ready && !abort;
                    end
                end else begin
                    prev_stall = 1'b0;
                    out_ready  = 1'($urandom_range(1, 0));
                end
            end
        end
        if (!fin) chk("timeout", 32'd0, 32'd1);
        out_ready = 1'b0;
        abort     = 1'b0;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        regs[0] = {N{1'b0}};
        for (int i = 5; i <= 10; i++) regs[i] = 32'h100 + i;

        // Reset state.
        #12;
        chk("rst_rreg", 32'(RReg), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done_err", 32'({done, err, out_last}), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        do_dump(5, 10, 0, 0, -1);
        do_dump(3, 4, 0, 7, -1);
        do_dump(31, 31, 0, 0, -1);
        do_dump(0, 31, 0, 0, -1);

        // Reversed range is refused with a single err pulse.
        first_addr = 5'd12;
        last_addr  = 5'd4;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("err_pulse", 32'(err), 32'd1);
        chk("err_busy", 32'(busy), 32'd0);
        chk("err_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("err_cleared", 32'(err), 32'd0);
        chk("err_busy2", 32'(busy), 32'd0);
        chk("err_valid2", 32'(out_valid), 32'd0);

        do_dump(0, 15, 0, 0, 2);
        do_dump(0, 1, 0, 0, -1);

        // Asynchronous reset in the middle of a dump.
        first_addr = 5'd0;
        last_addr  = 5'd31;
        start      = 1'b1;
        out_ready  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_rreg", 32'(RReg), 32'd0);
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_data", out_data, 32'd0);
        chk("arst_idx", 32'(out_idx), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_flags", 32'({done, err, out_last}), 32'd0);
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_valid", 32'(out_valid), 32'd0);

        // Random ranges and contents with random backpressure.
        for (int t = 0; t < 6; t++) begin
            int f;
            int l;
            for (int i = 1; i < 32; i++) regs[i] = $urandom;
            f = $urandom_range(31, 0);
            l = $urandom_range(31, f);
            do_dump(f, l, 1, 0, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
